vga_score_display: RTL and testbench

Parametrised decimal score renderer for the VGA pixel path: converts a binary score to N BCD digits with a sequential double-dabble engine, commits new digits only at frame start so no frame tears, and masks the current pixel with the glyph of each digit. It sits between the game-state logic (score source) and the final RGB mux, alongside the other `vga_*` overlay blocks. It adds saturation, leading-zero blanking and configurable width and digit count.

---
 rtl/vga_score_pkg.sv | 48 ++++
 rtl/vga_bcd_dabble.sv | 90 +++++++++
 rtl/vga_score2seg.sv | 50 +++++
 rtl/vga_score_display.sv | 79 +++++++
 tb/tb_vga_score_display.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_score_pkg.sv
// Shared types and constants for the decimal score overlay: conversion engine
// states, glyph cell geometry and the seven-segment decode table.
package vga_score_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PENDING = 2'd2
  } dabble_state_t;

  localparam int DIGIT_PITCH_DEF = 16;

  // Glyph cell: 12 x 22 pixels, 2-pixel strokes; the middle bar sits at rows 10..11.
  localparam int CELL_W = 12;
  localparam int CELL_H = 22;
  localparam int SEG_T  = 2;
  localparam int MID_Y  = (CELL_H - SEG_T) / 2;

  localparam logic [2:0] GLYPH_RGB = 3'b010;

  // Largest value representable in n decimal digits, evaluated at elaboration.
  function automatic int max_val(input int n_digits);
    int v;
    v = 1;
    for (int i = 0; i < n_digits; i++) v = v * 10;
    return v - 1;
  endfunction

  // Segment enables {a,b,c,d,e,f,g}; codes above 9 render nothing.
  function automatic logic [6:0] seg_mask(input logic [3:0] digit);
    logic [6:0] m;
    case (digit)
      4'd0:    m = 7'b1111110;
      4'd1:    m = 7'b0110000;
      4'd2:    m = 7'b1101101;
      4'd3:    m = 7'b1111001;
      4'd4:    m = 7'b0110011;
      4'd5:    m = 7'b1011011;
      4'd6:    m = 7'b1011111;
      4'd7:    m = 7'b1110000;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1111011;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_bcd_dabble.sv
// Sequential double-dabble converter: samples a changed score, shifts it into
// BCD over SCORE_W cycles, then holds the result until the next frame start.
module vga_bcd_dabble
  import vga_score_pkg::*;
#(
  parameter int SCORE_W  = 10,
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  frame_start,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  sat,
  output logic                  commit,
  output logic                  busy
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int MAX_VAL = max_val(N_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCORE_W - 1);

  dabble_state_t      state;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] bin_sh;
  logic [BCD_W-1:0]   bcd_sh;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_adj;
  logic               over_max;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < N_DIGITS; k++)
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction

  assign bcd_adj  = add3(bcd_sh);
  assign over_max = {{(32-SCORE_W){1'b0}}, score} > 32'(MAX_VAL);

  // NOTE: state registers use non-blocking assignments so every flop in this
  // block sees the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      last_score <= '0;
      bin_sh     <= '0;
      bcd_sh     <= '0;
      cnt        <= '0;
      sat        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (score != last_score) begin
            last_score <= score;
            bin_sh     <= score;
            bcd_sh     <= '0;
            cnt        <= '0;
            sat        <= over_max;
            state      <= CONVERT;
            busy       <= 1'b1;
          end
        end
        CONVERT: begin
          // Carries out of the top nibble are dropped; sat already flags them.
          {bcd_sh, bin_sh} <= {bcd_adj[BCD_W-2:0], bin_sh, 1'b0};
          cnt              <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= PENDING;
        end
        PENDING: begin
          if (frame_start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign commit  = (state == PENDING) && frame_start;
  assign bcd_out = bcd_sh;

endmodule

// File: rtl/vga_score2seg.sv
// One seven-segment digit cell: lights the pixel at (row, col) when it falls on
// an enabled stroke of the given BCD digit. Purely combinational.
module vga_score2seg
  import vga_score_pkg::*;
#(
  parameter int         X_POS = 0,
  parameter int         Y_POS = 0,
  parameter logic [2:0] COLOR = GLYPH_RGB
) (
  input  logic [3:0] digit,
  input  logic       enable,
  input  logic [9:0] row,
  input  logic [9:0] col,
  output logic [2:0] rgb
);

  int         dx;
  int         dy;
  logic [6:0] seg;
  logic       in_cell;
  logic       horiz;
  logic       left;
  logic       right;
  logic       upper;
  logic       lower;
  logic       on;

  // NOTE: every signal written here gets a value before any condition is
  // tested, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    dx      = int'(col) - X_POS;
    dy      = int'(row) - Y_POS;
    seg     = seg_mask(digit);
    in_cell = (dx >= 0) && (dx < CELL_W) && (dy >= 0) && (dy < CELL_H);
    horiz   = (dx >= SEG_T) && (dx < CELL_W - SEG_T);
    left    = (dx < SEG_T);
    right   = (dx >= CELL_W - SEG_T);
    upper   = (dy >= SEG_T) && (dy < MID_Y);
    lower   = (dy >= MID_Y + SEG_T) && (dy < CELL_H - SEG_T);
    on      = (seg[6] && horiz && (dy < SEG_T))
            | (seg[5] && right && upper)
            | (seg[4] && right && lower)
            | (seg[3] && horiz && (dy >= CELL_H - SEG_T))
            | (seg[2] && left  && lower)
            | (seg[1] && left  && upper)
            | (seg[0] && horiz && (dy >= MID_Y) && (dy < MID_Y + SEG_T));
    rgb     = (enable && in_cell && on) ? COLOR : 3'b000;
  end

endmodule

// File: rtl/vga_score_display.sv
// Decimal score overlay: converts the score to BCD, latches it at frame start
// so a frame never tears, and renders the digits with optional zero blanking.
module vga_score_display
  import vga_score_pkg::*;
#(
  parameter int         SCORE_W     = 10,
  parameter int         N_DIGITS    = 3,
  parameter int         X_OFFSET    = 100,
  parameter int         Y_OFFSET    = 40,
  parameter int         DIGIT_PITCH = DIGIT_PITCH_DEF,
  parameter bit         BLANK_LZ    = 1'b1,
  parameter logic [2:0] GLYPH_COLOR = GLYPH_RGB
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               frame_start,
  input  logic [9:0]         row,
  input  logic [9:0]         col,
  output logic [2:0]         rgb_score,
  output logic               busy
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam logic [BCD_W-1:0] ALL_NINES = {N_DIGITS{4'h9}};

  logic [BCD_W-1:0] bcd_out;
  logic [BCD_W-1:0] disp;
  logic             sat;
  logic             commit;
  logic [2:0]       digit_rgb [N_DIGITS];

  vga_bcd_dabble #(
    .SCORE_W  (SCORE_W),
    .N_DIGITS (N_DIGITS)
  ) u_dabble (
    .clk         (clk),
    .reset       (reset),
    .score       (score),
    .frame_start (frame_start),
    .bcd_out     (bcd_out),
    .sat         (sat),
    .commit      (commit),
    .busy        (busy)
  );

  always_ff @(posedge clk) begin
    if (reset)       disp <= '0;
    else if (commit) disp <= sat ? ALL_NINES : bcd_out;
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    logic lit;
    // A digit is shown if it or any more-significant digit is nonzero.
    if (BLANK_LZ && (i > 0)) begin : g_blank
      assign lit = |disp[BCD_W-1:4*i];
    end else begin : g_always
      assign lit = 1'b1;
    end

    vga_score2seg #(
      .X_POS (X_OFFSET + (N_DIGITS - 1 - i) * DIGIT_PITCH),
      .Y_POS (Y_OFFSET),
      .COLOR (GLYPH_COLOR)
    ) u_seg (
      .digit  (disp[4*i +: 4]),
      .enable (lit),
      .row    (row),
      .col    (col),
      .rgb    (digit_rgb[i])
    );
  end

  always_comb begin
    rgb_score = 3'b000;
    for (int i = 0; i < N_DIGITS; i++) rgb_score = rgb_score | digit_rgb[i];
  end

endmodule

// File: tb/tb_vga_score_display.sv
// Directed bench for vga_score_display: three instances (blanking on, blanking
// off, four digits) share stimulus; expected digits and glyph pixels are hand-set.
module tb_vga_score_display;
  import vga_score_pkg::*;

  localparam logic [2:0] COL = 3'b010;
  localparam int XO = 100;
  localparam int YO = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] score = '0;
  logic       frame_start = 1'b0;
  logic [9:0] row = '0;
  logic [9:0] col = '0;
  logic [2:0] rgb_a, rgb_nb, rgb_4;
  logic       busy_a, busy_nb, busy_4;

  int checks = 0;
  int errors = 0;

  // Probe points inside a cell: centres of a,b,c,d,e,f,g, then an always-dark spot.
  int pdx [8] = '{5, 10, 10, 5, 0, 0, 5, 5};
  int pdy [8] = '{0, 5, 15, 20, 15, 5, 10, 5};
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  vga_score_display #(.SCORE_W(10), .N_DIGITS(3), .X_OFFSET(XO), .Y_OFFSET(YO),
                      .DIGIT_PITCH(16), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .score(score), .frame_start(frame_start),
    .row(row), .col(col), .rgb_score(rgb_a), .busy(busy_a));

  vga_score_display #(.SCORE_W(10), .N_DIGITS(3), .X_OFFSET(XO), .Y_OFFSET(YO),
                      .DIGIT_PITCH(16), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .score(score), .frame_start(frame_start),
    .row(row), .col(col), .rgb_score(rgb_nb), .busy(busy_nb));

  vga_score_display #(.SCORE_W(10), .N_DIGITS(4), .X_OFFSET(XO), .Y_OFFSET(YO),
                      .DIGIT_PITCH(16), .BLANK_LZ(1'b1)) dut4 (
    .clk(clk), .reset(reset), .score(score), .frame_start(frame_start),
    .row(row), .col(col), .rgb_score(rgb_4), .busy(busy_4));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Expected pixel at probe p of a cell showing digit d (lit=0 -> blanked).
  function automatic logic [2:0] exp_rgb(input int d, input bit lit, input int p);
    logic [6:0] m;
    m = seg_tab[d];
    if (!lit || p == 7) return 3'b000;
    return m[6-p] ? COL : 3'b000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_to_pending(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (dut.u_dabble.state == PENDING) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    score = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy cycle %0d: got %b want 0", n, busy_a);
      end
    end
    checks++;
    if (dut.disp !== 12'h000) begin
      errors++;
      $display("FAIL reset_disp: got %h want 000", dut.disp);
    end
    // Ones cell shows "0"; tens and hundreds blanked; unblanked instance shows "0".
    for (int p = 0; p < 8; p++) begin
      row = 10'(YO + pdy[p]);
      col = 10'(XO + 32 + pdx[p]);
      #1;
      checks++;
      if (rgb_a !== exp_rgb(0, 1'b1, p)) begin
        errors++;
        $display("FAIL reset_ones p%0d: got %b want %b", p, rgb_a, exp_rgb(0, 1'b1, p));
      end
      col = 10'(XO + pdx[p]);
      #1;
      checks++;
      if (rgb_a !== 3'b000) begin
        errors++;
        $display("FAIL reset_hundreds_blank p%0d: got %b want 000", p, rgb_a);
      end
      checks++;
      if (rgb_nb !== exp_rgb(0, 1'b1, p)) begin
        errors++;
        $display("FAIL reset_nb_hundreds p%0d: got %b want %b", p, rgb_nb, exp_rgb(0, 1'b1, p));
      end
    end
  endtask

  task automatic test_convert_259();
    int digs [3] = '{2, 5, 9};
    score = 10'd259;
    tick();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL c259_busy_rise: got %b want 1", busy_a);
    end
    for (int n = 0; n < 9; n++) tick();
    checks++;
    if (dut.u_dabble.state !== CONVERT) begin
      errors++;
      $display("FAIL c259_still_convert: got %0d want %0d", dut.u_dabble.state, CONVERT);
    end
    tick();
    checks++;
    if (dut.u_dabble.state !== PENDING || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL c259_pending: state %0d busy %b want %0d/1", dut.u_dabble.state, busy_a, PENDING);
    end
    checks++;
    if (dut.disp !== 12'h000) begin
      errors++;
      $display("FAIL c259_no_early_commit: got %h want 000", dut.disp);
    end
    pulse_frame();
    checks++;
    if (dut.disp !== 12'h259 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL c259_commit: disp %h busy %b want 259/0", dut.disp, busy_a);
    end
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 8; p++) begin
        row = 10'(YO + pdy[p]);
        col = 10'(XO + 16 * c + pdx[p]);
        #1;
        checks++;
        if (rgb_a !== exp_rgb(digs[c], 1'b1, p)) begin
          errors++;
          $display("FAIL c259_glyph cell%0d p%0d: got %b want %b", c, p, rgb_a, exp_rgb(digs[c], 1'b1, p));
        end
      end
  endtask

  task automatic test_leading_zero();
    bit ok;
    score = 10'd7;
    tick();
    pulse_frame();  // arrives during CONVERT and must be ignored
    checks++;
    if (dut.disp !== 12'h259) begin
      errors++;
      $display("FAIL lz_missed_frame: got %h want 259", dut.disp);
    end
    run_to_pending(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lz_pending_timeout: got none want PENDING");
    end
    pulse_frame();
    checks++;
    if (dut.disp !== 12'h007) begin
      errors++;
      $display("FAIL lz_commit: got %h want 007", dut.disp);
    end
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 8; p++) begin
        row = 10'(YO + pdy[p]);
        col = 10'(XO + 16 * c + pdx[p]);
        #1;
        checks++;
        if (rgb_a !== exp_rgb((c == 2) ? 7 : 0, c == 2, p)) begin
          errors++;
          $display("FAIL lz_blank cell%0d p%0d: got %b want %b", c, p, rgb_a, exp_rgb((c == 2) ? 7 : 0, c == 2, p));
        end
        checks++;
        if (rgb_nb !== exp_rgb((c == 2) ? 7 : 0, 1'b1, p)) begin
          errors++;
          $display("FAIL lz_noblank cell%0d p%0d: got %b want %b", c, p, rgb_nb, exp_rgb((c == 2) ? 7 : 0, 1'b1, p));
        end
      end
  endtask

  task automatic test_saturate();
    bit ok;
    int digs4 [4] = '{1, 0, 2, 3};
    score = 10'd1023;
    tick();
    run_to_pending(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sat_pending_timeout: got none want PENDING");
    end
    checks++;
    if (dut.u_dabble.sat !== 1'b1 || dut4.u_dabble.sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_flag: got %b/%b want 1/0", dut.u_dabble.sat, dut4.u_dabble.sat);
    end
    pulse_frame();
    checks++;
    if (dut.disp !== 12'h999) begin
      errors++;
      $display("FAIL sat_disp3: got %h want 999", dut.disp);
    end
    checks++;
    if (dut4.disp !== 16'h1023) begin
      errors++;
      $display("FAIL sat_disp4: got %h want 1023", dut4.disp);
    end
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 8; p++) begin
        row = 10'(YO + pdy[p]);
        col = 10'(XO + 16 * c + pdx[p]);
        #1;
        checks++;
        if (rgb_4 !== exp_rgb(digs4[c], 1'b1, p)) begin
          errors++;
          $display("FAIL sat_glyph4 cell%0d p%0d: got %b want %b", c, p, rgb_4, exp_rgb(digs4[c], 1'b1, p));
        end
      end
  endtask

  task automatic test_back_to_back();
    bit ok;
    score = 10'd5;
    tick();
    tick();
    score = 10'd6;  // changes mid-conversion; picked up after the commit
    run_to_pending(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_first_timeout: got none want PENDING");
    end
    pulse_frame();
    checks++;
    if (dut.disp !== 12'h005) begin
      errors++;
      $display("FAIL b2b_first_commit: got %h want 005", dut.disp);
    end
    tick();
    checks++;
    if (busy_a !== 1'b1 || dut.u_dabble.state !== CONVERT) begin
      errors++;
      $display("FAIL b2b_restart: busy %b state %0d want 1/%0d", busy_a, dut.u_dabble.state, CONVERT);
    end
    run_to_pending(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_second_timeout: got none want PENDING");
    end
    checks++;
    if (dut.disp !== 12'h005) begin
      errors++;
      $display("FAIL b2b_hold: got %h want 005", dut.disp);
    end
    pulse_frame();
    checks++;
    if (dut.disp !== 12'h006) begin
      errors++;
      $display("FAIL b2b_second_commit: got %h want 006", dut.disp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    score = 10'd300;
    tick();
    for (int n = 0; n < 4; n++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dut.disp !== 12'h000 || busy_a !== 1'b0 || dut.u_dabble.state !== IDLE) begin
      errors++;
      $display("FAIL rmid_reset: disp %h busy %b state %0d want 000/0/%0d", dut.disp, busy_a, dut.u_dabble.state, IDLE);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL rmid_restart: got %b want 1", busy_a);
    end
    run_to_pending(ok);
    checks++;
    if (!ok || dut.disp !== 12'h000) begin
      errors++;
      $display("FAIL rmid_pending: ok %b disp %h want 1/000", ok, dut.disp);
    end
    pulse_frame();
    checks++;
    if (dut.disp !== 12'h300) begin
      errors++;
      $display("FAIL rmid_commit: got %h want 300", dut.disp);
    end
  endtask

  initial begin
    test_reset();
    test_convert_259();
    test_leading_zero();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
